// File: rtl/pipe_stage_reg_if.sv
// Stage-register port bundle: hazard controls, upstream payload in, registered payload out.
// Perf counter signals exist only when PIPE_STAGE_PERF_EN is defined.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 4
);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic [31:0]       pc_in;
  logic [31:0]       instr_in;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [31:0]       pc_out;
  logic [31:0]       instr_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_timeout;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       perf_stall;
  logic [31:0]       perf_bubble;

  modport master (
    output stall, flush, valid_in, ctrl_in, data_in, pc_in, instr_in,
    input  valid_out, ctrl_out, data_out, pc_out, instr_out, stall_cnt, stall_timeout,
    input  perf_stall, perf_bubble
  );
  modport slave (
    input  stall, flush, valid_in, ctrl_in, data_in, pc_in, instr_in,
    output valid_out, ctrl_out, data_out, pc_out, instr_out, stall_cnt, stall_timeout,
    output perf_stall, perf_bubble
  );
`else
  modport master (
    output stall, flush, valid_in, ctrl_in, data_in, pc_in, instr_in,
    input  valid_out, ctrl_out, data_out, pc_out, instr_out, stall_cnt, stall_timeout
  );
  modport slave (
    input  stall, flush, valid_in, ctrl_in, data_in, pc_in, instr_in,
    output valid_out, ctrl_out, data_out, pc_out, instr_out, stall_cnt, stall_timeout
  );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall hold, bubble insertion and a sticky stall watchdog.
// Optional PIPE_STAGE_PERF_EN adds stall/bubble event counters.
module pipe_stage_reg #(
  parameter int              CTRL_W      = 16,
  parameter int              DATA_W      = 128,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter logic [31:0]     PC_BUBBLE   = 32'h0000_3008,
  parameter int              CLEAR_DATA  = 1,
  parameter int              STALL_MAX   = 15,
  parameter int              CNT_W       = 4
) (
  input logic             clk,
  input logic             clr,
  pipe_stage_reg_if.slave stg
);

  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

  // Power-up values match the clr values
  logic              vld_p0   = 1'b0;
  logic [CTRL_W-1:0] ctrl_p0  = CTRL_BUBBLE;
  logic [DATA_W-1:0] data_p0  = '0;
  logic [31:0]       pc_p0    = PC_BUBBLE;
  logic [31:0]       instr_p0 = '0;
  logic [CNT_W-1:0]  stallCnt = '0;
  logic              stallTo  = 1'b0;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Stage p0: clr > flush > stall > load
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p0   <= 1'b0;
      ctrl_p0  <= CTRL_BUBBLE;
      data_p0  <= '0;
      pc_p0    <= PC_BUBBLE;
      instr_p0 <= '0;
      stallCnt <= '0;
      stallTo  <= 1'b0;
    end else if (stg.flush) begin
      vld_p0   <= 1'b0;
      ctrl_p0  <= CTRL_BUBBLE;
      pc_p0    <= PC_BUBBLE;
      if (CLEAR_DATA != 0) begin
        data_p0  <= '0;
        instr_p0 <= '0;
      end
      stallCnt <= '0;
    end else if (stg.stall) begin
      stallCnt <= satInc(stallCnt);
      if (satInc(stallCnt) == STALL_LIM) stallTo <= 1'b1;
    end else begin
      vld_p0   <= stg.valid_in;
      // A non-valid slot carries bubble control so it can never write state
      ctrl_p0  <= stg.valid_in ? stg.ctrl_in : CTRL_BUBBLE;
      data_p0  <= stg.data_in;
      pc_p0    <= stg.pc_in;
      instr_p0 <= stg.instr_in;
      stallCnt <= '0;
    end
  end

  assign stg.valid_out     = vld_p0;
  assign stg.ctrl_out      = ctrl_p0;
  assign stg.data_out      = data_p0;
  assign stg.pc_out        = pc_p0;
  assign stg.instr_out     = instr_p0;
  assign stg.stall_cnt     = stallCnt;
  assign stg.stall_timeout = stallTo;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perfStall  = '0;
  logic [31:0] perfBubble = '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      perfStall  <= '0;
      perfBubble <= '0;
    end else begin
      if (stg.stall && !stg.flush) perfStall <= perfStall + 32'd1;
      if (stg.flush || (!stg.stall && !stg.valid_in)) perfBubble <= perfBubble + 32'd1;
    end
  end

  assign stg.perf_stall  = perfStall;
  assign stg.perf_bubble = perfBubble;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus stall-watchdog and reset sequences.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(4)) a ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .CNT_W(4)) b ();

  // Second instance keeps data/instr on bubble; shares all stimulus with the first
  assign b.stall    = a.stall;
  assign b.flush    = a.flush;
  assign b.valid_in = a.valid_in;
  assign b.ctrl_in  = a.ctrl_in;
  assign b.data_in  = a.data_in;
  assign b.pc_in    = a.pc_in;
  assign b.instr_in = a.instr_in;

  pipe_stage_reg #(.CLEAR_DATA(1)) dutA (.clk(clk), .clr(clr), .stg(a));
  pipe_stage_reg #(.CLEAR_DATA(0)) dutB (.clk(clk), .clr(clr), .stg(b));

  typedef struct {
    logic         stall, flush, vin;
    logic [15:0]  ctrl;
    logic [127:0] data;
    logic [31:0]  pc, instr;
    logic         eV;
    logic [15:0]  eCtrl;
    logic [127:0] eData, eDataB;
    logic [31:0]  ePc, eInstr, eInstrB;
    logic [3:0]   eCnt;
    logic         eTo;
  } vec_t;

  vec_t tv[10];
  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] d9;
    d9 = {4{32'hDEAD_BEEF}};
    tv[0] = '{1'b0,1'b0,1'b1,16'h00A5,128'h1234,32'h3010,32'h8C01_0004,
              1'b1,16'h00A5,128'h1234,128'h1234,32'h3010,32'h8C01_0004,32'h8C01_0004,4'd0,1'b0};
    tv[1] = '{1'b1,1'b0,1'b1,16'h0011,128'h5555,32'h3014,32'h1111,
              1'b1,16'h00A5,128'h1234,128'h1234,32'h3010,32'h8C01_0004,32'h8C01_0004,4'd1,1'b0};
    tv[2] = tv[1]; tv[2].eCnt = 4'd2;
    tv[3] = tv[1]; tv[3].eCnt = 4'd3;
    tv[4] = '{1'b0,1'b0,1'b1,16'h0011,128'h5555,32'h3014,32'h1111,
              1'b1,16'h0011,128'h5555,128'h5555,32'h3014,32'h1111,32'h1111,4'd0,1'b0};
    tv[5] = '{1'b1,1'b1,1'b1,16'h0022,128'h6666,32'h3018,32'h2222,
              1'b0,16'h0000,128'h0,128'h5555,32'h3008,32'h0,32'h1111,4'd0,1'b0};
    tv[6] = '{1'b0,1'b0,1'b0,16'h0033,128'h7777,32'h301C,32'h3333,
              1'b0,16'h0000,128'h7777,128'h7777,32'h301C,32'h3333,32'h3333,4'd0,1'b0};
    tv[7] = '{1'b1,1'b0,1'b1,16'h0044,128'h8888,32'h3020,32'h4444,
              1'b0,16'h0000,128'h7777,128'h7777,32'h301C,32'h3333,32'h3333,4'd1,1'b0};
    tv[8] = '{1'b0,1'b1,1'b1,16'h0044,128'h8888,32'h3020,32'h4444,
              1'b0,16'h0000,128'h0,128'h7777,32'h3008,32'h0,32'h3333,4'd0,1'b0};
    tv[9] = '{1'b0,1'b0,1'b1,16'hFFFF,d9,32'h3020,32'hFFFF_FFFF,
              1'b1,16'hFFFF,d9,d9,32'h3020,32'hFFFF_FFFF,32'hFFFF_FFFF,4'd0,1'b0};

    // Reset with junk on the inputs
    clr = 1'b1;
    a.stall = 1'b0; a.flush = 1'b0; a.valid_in = 1'b1;
    a.ctrl_in = 16'hBEEF; a.data_in = 128'hABCD; a.pc_in = 32'h4000; a.instr_in = 32'h1234_5678;
    step();
    chk("rst valid", 128'(a.valid_out), 128'(1'b0));
    chk("rst ctrl", 128'(a.ctrl_out), 128'(16'h0000));
    chk("rst pc", 128'(a.pc_out), 128'(32'h3008));
    chk("rst data", a.data_out, 128'h0);
    chk("rst instr", 128'(a.instr_out), 128'(32'h0));
    chk("rst cnt", 128'(a.stall_cnt), 128'(4'd0));
    chk("rst timeout", 128'(a.stall_timeout), 128'(1'b0));
    clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      a.stall = tv[i].stall; a.flush = tv[i].flush; a.valid_in = tv[i].vin;
      a.ctrl_in = tv[i].ctrl; a.data_in = tv[i].data; a.pc_in = tv[i].pc; a.instr_in = tv[i].instr;
      step();
      chk($sformatf("v%0d valid", i), 128'(a.valid_out), 128'(tv[i].eV));
      chk($sformatf("v%0d ctrl", i), 128'(a.ctrl_out), 128'(tv[i].eCtrl));
      chk($sformatf("v%0d data", i), a.data_out, tv[i].eData);
      chk($sformatf("v%0d pc", i), 128'(a.pc_out), 128'(tv[i].ePc));
      chk($sformatf("v%0d instr", i), 128'(a.instr_out), 128'(tv[i].eInstr));
      chk($sformatf("v%0d cnt", i), 128'(a.stall_cnt), 128'(tv[i].eCnt));
      chk($sformatf("v%0d timeout", i), 128'(a.stall_timeout), 128'(tv[i].eTo));
      chk($sformatf("v%0d holdData", i), b.data_out, tv[i].eDataB);
      chk($sformatf("v%0d holdInstr", i), 128'(b.instr_out), 128'(tv[i].eInstrB));
      chk($sformatf("v%0d holdPc", i), 128'(b.pc_out), 128'(tv[i].ePc));
    end

`ifdef PIPE_STAGE_PERF_EN
    chk("perf stall", 128'(a.perf_stall), 128'(32'd4));
    chk("perf bubble", 128'(a.perf_bubble), 128'(32'd3));
`endif

    // Long stall: watchdog fires on the 15th edge, counter saturates
    a.stall = 1'b1; a.flush = 1'b0; a.pc_in = 32'h5000;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("wd%0d cnt", i), 128'(a.stall_cnt), 128'((i < 15) ? i : 15));
      chk($sformatf("wd%0d timeout", i), 128'(a.stall_timeout), 128'(i >= 15));
      chk($sformatf("wd%0d pc", i), 128'(a.pc_out), 128'(32'h3020));
    end
    a.stall = 1'b0; a.pc_in = 32'h3024; a.valid_in = 1'b1;
    step();
    chk("wdLoad cnt", 128'(a.stall_cnt), 128'(4'd0));
    chk("wdLoad timeout", 128'(a.stall_timeout), 128'(1'b1));
    chk("wdLoad pc", 128'(a.pc_out), 128'(32'h3024));
    a.flush = 1'b1;
    step();
    chk("wdFlush timeout", 128'(a.stall_timeout), 128'(1'b1));
    chk("wdFlush valid", 128'(a.valid_out), 128'(1'b0));

    // clr in the middle of a stall
    a.flush = 1'b0; a.stall = 1'b1;
    step();
    step();
    chk("midStall cnt", 128'(a.stall_cnt), 128'(4'd2));
    clr = 1'b1;
    step();
    chk("clrStall cnt", 128'(a.stall_cnt), 128'(4'd0));
    chk("clrStall timeout", 128'(a.stall_timeout), 128'(1'b0));
    chk("clrStall valid", 128'(a.valid_out), 128'(1'b0));
    chk("clrStall pc", 128'(a.pc_out), 128'(32'h3008));
    chk("clrStall holdData", b.data_out, 128'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("clr perf stall", 128'(a.perf_stall), 128'(32'd0));
    chk("clr perf bubble", 128'(a.perf_bubble), 128'(32'd0));
`endif
    clr = 1'b0;
    a.stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
